// File: rtl/cp0_pkg.sv
// cp0_pkg
//  Shared constants for the CP0 slice: CP0 register numbers, MIPS ExcCode values,
//  and the bit positions of the Status and Cause fields used by the parent and the bench.
//  No ports; imported by cp0_timer and cp0_exc_unit.
package cp0_pkg;

   // CP0 register numbers (rd field of mtc0/mfc0, select 0)
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;
   localparam logic [4:0] REG_CONFIG   = 5'd16;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // Status field positions
   localparam int ST_IE    = 0;
   localparam int ST_EXL   = 1;
   localparam int ST_IM_LO = 8;
   localparam int ST_IM_HI = 15;
   localparam int ST_BEV   = 22;

   // Cause field positions
   localparam int CA_EXC_LO = 2;
   localparam int CA_EXC_HI = 6;
   localparam int CA_IP_LO  = 8;
   localparam int CA_IP_HI  = 15;
   localparam int CA_TI     = 30;
   localparam int CA_BD     = 31;

   // Only address-error exceptions capture a faulting address into BadVAddr.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == 5'(EXC_ADEL)) || (code == 5'(EXC_ADES));
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer
//  Count/Compare timer. A prescaler divides clk by COUNT_DIV; Count increments on each
//  prescaler wrap. TI is a sticky flag set when the incremented Count equals Compare and
//  cleared by any Compare write.
// Ports
//  clk, rst            clock, asynchronous active-high reset
//  count_we/_wdata     load Count (also clears the prescaler)
//  compare_we/_wdata   load Compare (also clears TI)
//  count, compare, ti  live register values
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic [31:0] count_wdata,
   input  logic        compare_we,
   input  logic [31:0] compare_wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);
   import cp0_pkg::*;

   localparam int PS_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(COUNT_DIV - 1);

   logic [PS_W-1:0] prescale_reg, prescale_next;
   logic [31:0]     count_reg, count_next;
   logic [31:0]     compare_reg, compare_next;
   logic            ti_reg, ti_next;
   logic            tick;
   logic [31:0]     count_inc;
   logic            ti_set;

   always_comb begin
      tick      = (prescale_reg == PS_MAX);
      count_inc = count_reg + 32'd1;
      // The match is judged on the free-running increment, so a simultaneous
      // Count write cannot hide a match that was about to happen.
      ti_set    = tick && (count_inc == compare_reg);

      prescale_next = tick ? '0 : prescale_reg + PS_W'(1);
      count_next    = tick ? count_inc : count_reg;
      if (count_we) begin
         count_next    = count_wdata;
         prescale_next = '0;
      end

      compare_next = compare_we ? compare_wdata : compare_reg;
      // A Compare write re-arms the timer, so it clears even a coincident match.
      ti_next      = compare_we ? 1'b0 : (ti_reg | ti_set);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_reg <= '0;
         count_reg    <= '0;
         compare_reg  <= '0;
         ti_reg       <= 1'b0;
      end else begin
         prescale_reg <= prescale_next;
         count_reg    <= count_next;
         compare_reg  <= compare_next;
         ti_reg       <= ti_next;
      end
   end

   assign count   = count_reg;
   assign compare = compare_reg;
   assign ti      = ti_reg;

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
//  MIPS32 CP0 beside the MEM/WB boundary: Status, Cause, EPC, BadVAddr, PRId, Config and the
//  Count/Compare timer (cp0_timer). Handles precise exception entry and ERET return.
// Ports
//  clk, rst                        clock, asynchronous active-high reset
//  mtc0_we/_addr/_wdata            CP0 register write
//  mfc0_addr / mfc0_rdata          combinational CP0 register read
//  exc_valid/_code/_bd/_pc/_badvaddr  committed exception
//  eret                            committed ERET
//  hw_int                          level-sensitive external interrupts
//  int_req                         registered interrupt request
//  flush, redirect_pc              pipeline flush and new fetch PC
//  status_o, cause_o, epc_o        live register values
module cp0_exc_unit #(
   parameter int          N_HW      = 6,
   parameter int          COUNT_DIV = 2,
   parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
   parameter logic [31:0] PRID_VAL  = 32'h00004220,
   parameter logic [31:0] CFG_VAL   = 32'h00008000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mtc0_we,
   input  logic [4:0]      mtc0_addr,
   input  logic [31:0]     mtc0_wdata,
   input  logic [4:0]      mfc0_addr,
   output logic [31:0]     mfc0_rdata,
   input  logic            exc_valid,
   input  logic [4:0]      exc_code,
   input  logic            exc_bd,
   input  logic [31:0]     exc_pc,
   input  logic [31:0]     exc_badvaddr,
   input  logic            eret,
   input  logic [N_HW-1:0] hw_int,
   output logic            int_req,
   output logic            flush,
   output logic [31:0]     redirect_pc,
   output logic [31:0]     status_o,
   output logic [31:0]     cause_o,
   output logic [31:0]     epc_o
);
   import cp0_pkg::*;

   logic [7:0]  im_reg, im_next;
   logic        exl_reg, exl_next;
   logic        ie_reg, ie_next;
   logic        bd_reg, bd_next;
   logic [4:0]  exc_code_reg, exc_code_next;
   logic [1:0]  ip_sw_reg, ip_sw_next;
   logic [5:0]  ip_hw_reg;
   logic [31:0] epc_reg, epc_next;
   logic [31:0] badvaddr_reg, badvaddr_next;
   logic        int_req_reg, int_req_next;

   logic [31:0] count, compare;
   logic        ti;
   logic [5:0]  hw_ext;
   logic [7:0]  ip_vec;
   logic [31:0] status_val, cause_val;
   logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;

   // Lines beyond N_HW are tied low so their IP bits read 0.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_hw
         if (gi < N_HW) begin : g_used
            assign hw_ext[gi] = hw_int[gi];
         end else begin : g_tied
            assign hw_ext[gi] = 1'b0;
         end
      end
   endgenerate

   assign wr_status  = mtc0_we && (mtc0_addr == REG_STATUS);
   assign wr_cause   = mtc0_we && (mtc0_addr == REG_CAUSE);
   assign wr_epc     = mtc0_we && (mtc0_addr == REG_EPC);
   assign wr_count   = mtc0_we && (mtc0_addr == REG_COUNT);
   assign wr_compare = mtc0_we && (mtc0_addr == REG_COMPARE);

   cp0_timer #(
      .COUNT_DIV(COUNT_DIV)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .count_we     (wr_count),
      .count_wdata  (mtc0_wdata),
      .compare_we   (wr_compare),
      .compare_wdata(mtc0_wdata),
      .count        (count),
      .compare      (compare),
      .ti           (ti)
   );

   // IP[15] shares the top hardware line with the timer flag.
   assign ip_vec = {ip_hw_reg[5] | ti, ip_hw_reg[4:0], ip_sw_reg};

   always_comb begin
      status_val = '0;
      status_val[ST_BEV]            = 1'b1;
      status_val[ST_IM_HI:ST_IM_LO] = im_reg;
      status_val[ST_EXL]            = exl_reg;
      status_val[ST_IE]             = ie_reg;

      cause_val = '0;
      cause_val[CA_BD]               = bd_reg;
      cause_val[CA_TI]               = ti;
      cause_val[CA_IP_HI:CA_IP_LO]   = ip_vec;
      cause_val[CA_EXC_HI:CA_EXC_LO] = exc_code_reg;
   end

   // Next-state: the three sources are applied lowest priority first, so a
   // later (higher-priority) assignment to the same field overrides.
   always_comb begin
      im_next       = im_reg;
      exl_next      = exl_reg;
      ie_next       = ie_reg;
      bd_next       = bd_reg;
      exc_code_next = exc_code_reg;
      ip_sw_next    = ip_sw_reg;
      epc_next      = epc_reg;
      badvaddr_next = badvaddr_reg;

      if (wr_status) begin
         im_next  = mtc0_wdata[ST_IM_HI:ST_IM_LO];
         exl_next = mtc0_wdata[ST_EXL];
         ie_next  = mtc0_wdata[ST_IE];
      end
      if (wr_cause) begin
         ip_sw_next = mtc0_wdata[CA_IP_LO+1:CA_IP_LO];
      end
      // An exception owns EPC in its cycle even when nested leaves it unchanged.
      if (wr_epc && !exc_valid) begin
         epc_next = mtc0_wdata;
      end

      if (eret) begin
         exl_next = 1'b0;
      end

      if (exc_valid) begin
         exl_next      = 1'b1;
         exc_code_next = exc_code;
         if (!exl_reg) begin
            epc_next = exc_bd ? (exc_pc - 32'd4) : exc_pc;
            bd_next  = exc_bd;
         end
         if (is_addr_exc(exc_code)) begin
            badvaddr_next = exc_badvaddr;
         end
      end

      int_req_next = ie_reg && !exl_reg && (|(ip_vec & im_reg));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         exc_code_reg <= '0;
         ip_sw_reg    <= '0;
         ip_hw_reg    <= '0;
         epc_reg      <= '0;
         badvaddr_reg <= '0;
         int_req_reg  <= 1'b0;
      end else begin
         im_reg       <= im_next;
         exl_reg      <= exl_next;
         ie_reg       <= ie_next;
         bd_reg       <= bd_next;
         exc_code_reg <= exc_code_next;
         ip_sw_reg    <= ip_sw_next;
         ip_hw_reg    <= hw_ext;
         epc_reg      <= epc_next;
         badvaddr_reg <= badvaddr_next;
         int_req_reg  <= int_req_next;
      end
   end

   always_comb begin
      case (mfc0_addr)
         REG_BADVADDR: mfc0_rdata = badvaddr_reg;
         REG_COUNT:    mfc0_rdata = count;
         REG_COMPARE:  mfc0_rdata = compare;
         REG_STATUS:   mfc0_rdata = status_val;
         REG_CAUSE:    mfc0_rdata = cause_val;
         REG_EPC:      mfc0_rdata = epc_reg;
         REG_PRID:     mfc0_rdata = PRID_VAL;
         REG_CONFIG:   mfc0_rdata = CFG_VAL;
         default:      mfc0_rdata = '0;
      endcase
   end

   assign int_req     = int_req_reg;
   assign flush       = exc_valid | eret;
   assign redirect_pc = exc_valid ? EXC_VEC : epc_reg;
   assign status_o    = status_val;
   assign cause_o     = cause_val;
   assign epc_o       = epc_reg;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit
//  Directed bench for cp0_exc_unit with a cycle-level reference model of the CP0
//  architectural state. A negedge process compares every output to the model; the
//  stimulus process also checks hand-computed literal values.
module tb_cp0_exc_unit;
   localparam int          N_HW      = 6;
   localparam int          COUNT_DIV = 2;
   localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
   localparam logic [31:0] PRID_VAL  = 32'h00004220;
   localparam logic [31:0] CFG_VAL   = 32'h00008000;

   logic            clk = 1'b0;
   logic            rst;
   logic            mtc0_we = 1'b0;
   logic [4:0]      mtc0_addr = '0;
   logic [31:0]     mtc0_wdata = '0;
   logic [4:0]      mfc0_addr = '0;
   logic [31:0]     mfc0_rdata;
   logic            exc_valid = 1'b0;
   logic [4:0]      exc_code = '0;
   logic            exc_bd = 1'b0;
   logic [31:0]     exc_pc = '0;
   logic [31:0]     exc_badvaddr = '0;
   logic            eret = 1'b0;
   logic [N_HW-1:0] hw_int = '0;
   logic            int_req;
   logic            flush;
   logic [31:0]     redirect_pc;
   logic [31:0]     status_o, cause_o, epc_o;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   cp0_exc_unit #(
      .N_HW(N_HW), .COUNT_DIV(COUNT_DIV), .EXC_VEC(EXC_VEC),
      .PRID_VAL(PRID_VAL), .CFG_VAL(CFG_VAL)
   ) dut (
      .clk(clk), .rst(rst),
      .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
      .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd),
      .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .eret(eret),
      .hw_int(hw_int), .int_req(int_req), .flush(flush), .redirect_pc(redirect_pc),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Count is derived from the cycles elapsed since the last load, not from a prescaler.
   logic [31:0] m_base, m_compare, m_epc, m_bva;
   int          m_cyc;
   logic        m_ti, m_exl, m_ie, m_bd, m_intreq;
   logic [7:0]  m_im;
   logic [4:0]  m_code;
   logic [1:0]  m_ip_sw;
   logic [5:0]  m_ip_hw;

   function automatic logic [31:0] m_count_at(input int cyc);
      return m_base + 32'(cyc / COUNT_DIV);
   endfunction

   function automatic logic [7:0] m_ip();
      return {m_ip_hw[5] | m_ti, m_ip_hw[4:0], m_ip_sw};
   endfunction

   function automatic logic [31:0] m_status();
      return 32'h00400000 | ({24'd0, m_im} << 8) | ({31'd0, m_exl} << 1) | {31'd0, m_ie};
   endfunction

   function automatic logic [31:0] m_cause();
      return ({31'd0, m_bd} << 31) | ({31'd0, m_ti} << 30) | ({24'd0, m_ip()} << 8)
             | ({27'd0, m_code} << 2);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_bva;
         5'd9:    return m_count_at(m_cyc);
         5'd11:   return m_compare;
         5'd12:   return m_status();
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         5'd15:   return PRID_VAL;
         5'd16:   return CFG_VAL;
         default: return 32'd0;
      endcase
   endfunction

   // Next architectural state from the current inputs (priority exc > eret > mtc0).
   logic [31:0] n_base, n_compare, n_epc, n_bva;
   int          n_cyc;
   logic        n_ti, n_exl, n_ie, n_bd, n_intreq, n_tiset;
   logic [7:0]  n_im;
   logic [4:0]  n_code;
   logic [1:0]  n_ip_sw;

   always @* begin
      n_tiset = (m_count_at(m_cyc + 1) != m_count_at(m_cyc))
                && (m_count_at(m_cyc + 1) == m_compare);
      n_base = m_base; n_cyc = m_cyc + 1;
      if (mtc0_we && mtc0_addr == 5'd9) begin
         n_base = mtc0_wdata; n_cyc = 0;
      end
      n_compare = (mtc0_we && mtc0_addr == 5'd11) ? mtc0_wdata : m_compare;
      n_ti      = (mtc0_we && mtc0_addr == 5'd11) ? 1'b0 : (m_ti | n_tiset);
      n_im = m_im; n_ie = m_ie; n_exl = m_exl;
      if (mtc0_we && mtc0_addr == 5'd12) begin
         n_im = mtc0_wdata[15:8]; n_ie = mtc0_wdata[0]; n_exl = mtc0_wdata[1];
      end
      n_ip_sw = (mtc0_we && mtc0_addr == 5'd13) ? mtc0_wdata[9:8] : m_ip_sw;
      n_bd = m_bd; n_code = m_code; n_epc = m_epc; n_bva = m_bva;
      if (exc_valid) begin
         n_exl  = 1'b1;
         n_code = exc_code;
         if (!m_exl) begin
            n_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
            n_bd  = exc_bd;
         end
         if (exc_code == 5'd4 || exc_code == 5'd5) n_bva = exc_badvaddr;
      end else begin
         if (eret) n_exl = 1'b0;
         if (mtc0_we && mtc0_addr == 5'd14) n_epc = mtc0_wdata;
      end
      n_intreq = m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_base <= '0; m_cyc <= 0; m_compare <= '0; m_ti <= 1'b0;
         m_im <= '0; m_exl <= 1'b0; m_ie <= 1'b0; m_bd <= 1'b0; m_code <= '0;
         m_ip_sw <= '0; m_ip_hw <= '0; m_epc <= '0; m_bva <= '0; m_intreq <= 1'b0;
      end else begin
         m_base <= n_base; m_cyc <= n_cyc; m_compare <= n_compare; m_ti <= n_ti;
         m_im <= n_im; m_exl <= n_exl; m_ie <= n_ie; m_bd <= n_bd; m_code <= n_code;
         m_ip_sw <= n_ip_sw; m_ip_hw <= hw_int; m_epc <= n_epc; m_bva <= n_bva;
         m_intreq <= n_intreq;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_status", status_o, m_status());
         chk("cmp_cause", cause_o, m_cause());
         chk("cmp_epc", epc_o, m_epc);
         chk("cmp_int_req", {31'd0, int_req}, {31'd0, m_intreq});
         chk("cmp_flush", {31'd0, flush}, {31'd0, exc_valid | eret});
         chk("cmp_redirect", redirect_pc, exc_valid ? EXC_VEC : m_epc);
         chk("cmp_mfc0", mfc0_rdata, m_read(mfc0_addr));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
      cyc();
      mtc0_we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      cyc();
      mfc0_addr = a;
      #1;
      chk(name, mfc0_rdata, exp);
   endtask

   task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                      input logic [31:0] bva);
      exc_valid = 1'b1; exc_code = code; exc_bd = bd; exc_pc = pc; exc_badvaddr = bva;
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // 1. reset values and Count rate
      rd(5'd12, 32'h00400000, "rst_status");
      rd(5'd13, 32'h0, "rst_cause");
      rd(5'd14, 32'h0, "rst_epc");
      rd(5'd15, PRID_VAL, "rst_prid");
      repeat (5) cyc();
      rd(5'd9, 32'd5, "count_10clk");

      // 2. timer interrupt
      wr(5'd12, 32'h00008001);
      wr(5'd9, 32'd0);
      wr(5'd11, 32'd8);
      mfc0_addr = 5'd9;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         if (cause_o[30]) seen = 1'b1;
      end
      chk("ti_timeout", {31'd0, seen}, 32'd1);
      chk("ti_count", mfc0_rdata, 32'd8);
      chk("ti_ip15", {31'd0, cause_o[15]}, 32'd1);
      chk("ti_int_early", {31'd0, int_req}, 32'd0);
      cyc();
      chk("ti_int_req", {31'd0, int_req}, 32'd1);
      wr(5'd11, 32'h00010000);
      chk("ti_clear", {31'd0, cause_o[30]}, 32'd0);
      cyc();
      chk("ti_int_clear", {31'd0, int_req}, 32'd0);

      // 3. address-error exception in a delay slot
      exc(5'd4, 1'b1, 32'h80001004, 32'h00000123);
      #1;
      chk("exc_flush", {31'd0, flush}, 32'd1);
      chk("exc_redirect", redirect_pc, EXC_VEC);
      cyc();
      exc_valid = 1'b0;
      rd(5'd14, 32'h80001000, "exc_epc");
      rd(5'd13, 32'h80000010, "exc_cause");
      rd(5'd8, 32'h00000123, "exc_badva");
      chk("exc_status", status_o, 32'h00408003);

      // 4. nested exception, then eret
      exc(5'd8, 1'b0, 32'h80002000, 32'h00000456);
      cyc();
      exc_valid = 1'b0;
      rd(5'd14, 32'h80001000, "nest_epc");
      rd(5'd13, 32'h80000020, "nest_cause");
      rd(5'd8, 32'h00000123, "nest_badva");
      eret = 1'b1;
      #1;
      chk("eret_redirect", redirect_pc, 32'h80001000);
      chk("eret_flush", {31'd0, flush}, 32'd1);
      cyc();
      eret = 1'b0;
      chk("eret_status", status_o, 32'h00408001);

      // 5. simultaneous events
      exc(5'd12, 1'b0, 32'h80003000, 32'h0);
      mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_wdata = 32'h0000DEAD;
      cyc();
      exc_valid = 1'b0; mtc0_we = 1'b0;
      rd(5'd14, 32'h80003000, "prio_epc");
      eret = 1'b1;
      mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h00008003;
      cyc();
      eret = 1'b0; mtc0_we = 1'b0;
      chk("prio_exl", status_o, 32'h00408001);
      wr(5'd13, 32'hFFFFFFFF);
      rd(5'd13, 32'h00000330, "cause_sw_ip");
      wr(5'd13, 32'h0);

      // 6. hardware interrupt, then asynchronous reset
      wr(5'd12, 32'h00001001);
      hw_int = 6'b000100;
      cyc();
      chk("hw_int_early", {31'd0, int_req}, 32'd0);
      cyc();
      chk("hw_int_req", {31'd0, int_req}, 32'd1);
      mfc0_addr = 5'd9;
      #1 rst = 1'b1;
      #1;
      chk("arst_count", mfc0_rdata, 32'd0);
      chk("arst_int_req", {31'd0, int_req}, 32'd0);
      chk("arst_status", status_o, 32'h00400000);
      @(posedge clk);
      #1 rst = 1'b0;
      hw_int = '0;
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
